// File: rtl/spi_receiver.sv
// spi_receiver: oversampled SPI shift-in endpoint, MSB-first capture on sck falling edges,
// with a one-deep valid/ready output register and overrun/abort pulses.
module spi_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [3:0]            i_data_length,
  input  logic                  i_sck,
  input  logic                  i_mosi,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_abort
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync;
  logic                  r_sck_prev;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt, r_len;
  logic                  w_sck, w_mosi, w_fall;
  logic [CW-1:0]         w_len, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_word, w_mask;
  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_fall    = r_sck_prev & ~w_sck;
  // Zero or oversized lengths fall back to a full-width word
  assign w_len     = (i_data_length == 4'd0 || 32'(i_data_length) > DATA_WIDTH) ? CW'(DATA_WIDTH) : CW'(i_data_length);
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_word    = {r_shift[DATA_WIDTH-2:0], w_mosi};
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << r_len);
  assign o_busy    = (r_state == RECV);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_abort     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_prev  <= w_sck;
      o_overrun   <= 1'b0;
      o_abort     <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      // A start pulse outranks a coincident fall event
      if (i_start) begin
        r_state <= RECV;
        r_shift <= '0;
        r_cnt   <= '0;
        r_len   <= w_len;
        o_abort <= (r_state == RECV) && (r_cnt != '0);
      end else if (r_state == RECV && w_fall) begin
        r_shift <= w_word;
        r_cnt   <= w_cnt_nxt;
        if (w_cnt_nxt == r_len) begin
          o_data    <= w_word & w_mask;
          o_valid   <= 1'b1;
          o_overrun <= o_valid & ~i_ready;
          r_state   <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: scoreboard bench for spi_receiver; expected words queued at frame start,
// compared when o_busy drops on frame completion.
module tb_spi_receiver;
  logic       i_clk = 0, i_rst = 1, i_start = 0, i_sck = 0, i_mosi = 0, i_ready = 0;
  logic [3:0] i_data_length = 0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_overrun, o_abort;
  int         n_total = 0, n_pass = 0, ov_cycles = 0, ab_cycles = 0;
  logic [7:0] sb_q[$];
  logic       prev_busy = 0;
  spi_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data_length(i_data_length),
    .i_sck(i_sck), .i_mosi(i_mosi), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
    .o_busy(o_busy), .o_overrun(o_overrun), .o_abort(o_abort));
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  always @(negedge i_clk) begin
    if (i_rst) prev_busy <= 1'b0;
    else begin
      if (o_overrun) ov_cycles++;
      if (o_abort) ab_cycles++;
      if (prev_busy && !o_busy) begin
        if (sb_q.size() == 0) check("unexpected_word", 32'(o_data), 32'hFFFF_FFFF);
        else check("word", 32'(o_data), 32'(sb_q.pop_front()));
        check("valid_on_done", 32'(o_valid), 1);
      end
      prev_busy <= o_busy;
    end
  end
  task automatic tick();
    @(posedge i_clk); #1;
  endtask
  task automatic send_bit(input logic b, input logic rdy_on_done);
    tick(); i_sck = 1; i_mosi = b;
    repeat (3) tick();
    tick(); i_sck = 0;
    if (rdy_on_done) begin
      repeat (2) tick();
      i_ready = 1;
      tick(); i_ready = 0;
    end else repeat (3) tick();
    tick();
  endtask
  task automatic start(input logic [3:0] len);
    tick(); i_start = 1; i_data_length = len;
    tick(); i_start = 0;
  endtask
  task automatic send_frame(input logic [3:0] len, input logic [7:0] val, input logic rdy_last);
    int n;
    n = (len == 0 || len > 8) ? 8 : int'(len);
    start(len);
    sb_q.push_back(val & 8'((9'h1 << n) - 1));
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], rdy_last && i == 0);
  endtask
  task automatic consume();
    tick(); i_ready = 1;
    tick(); i_ready = 0;
  endtask
  initial begin
    int ov0, ab0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_data", 32'(o_data), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_abort", 32'(o_abort), 0);
    i_rst = 0;
    start(4'd8);
    check("busy_after_start", 32'(o_busy), 1);
    sb_q.push_back(8'h32);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h32 >> i), 1'b0);
    check("len8_data", 32'(o_data), 32'h32);
    check("len8_valid", 32'(o_valid), 1);
    check("len8_busy", 32'(o_busy), 0);
    consume();
    check("consume_valid", 32'(o_valid), 0);
    check("consume_hold", 32'(o_data), 32'h32);
    send_frame(4'd4, 8'h0B, 1'b0);
    check("len4_data", 32'(o_data), 32'h0B);
    consume();
    send_frame(4'd0, 8'hA5, 1'b0);
    check("len0_busy", 32'(o_busy), 0);
    check("len0_data", 32'(o_data), 32'hA5);
    consume();
    send_frame(4'd12, 8'hA5, 1'b0);
    check("len12_busy", 32'(o_busy), 0);
    check("len12_data", 32'(o_data), 32'hA5);
    consume();
    ov0 = ov_cycles;
    send_frame(4'd8, 8'h11, 1'b0);
    send_frame(4'd8, 8'h22, 1'b0);
    check("ovr_data", 32'(o_data), 32'h22);
    check("ovr_valid", 32'(o_valid), 1);
    check("ovr_pulses", 32'(ov_cycles - ov0), 1);
    consume();
    ov0 = ov_cycles;
    send_frame(4'd8, 8'h11, 1'b0);
    send_frame(4'd8, 8'h22, 1'b1);
    check("acc_data", 32'(o_data), 32'h22);
    check("acc_valid", 32'(o_valid), 1);
    check("acc_no_overrun", 32'(ov_cycles - ov0), 0);
    consume();
    ab0 = ab_cycles;
    start(4'd8);
    start(4'd8);
    check("rearm_silent", 32'(ab_cycles - ab0), 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    send_frame(4'd8, 8'h3C, 1'b0);
    check("abort_pulses", 32'(ab_cycles - ab0), 1);
    check("abort_data", 32'(o_data), 32'h3C);
    ab0 = ab_cycles;
    start(4'd8);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
    tick(); i_rst = 1;
    #1;
    check("arst_data", 32'(o_data), 0);
    check("arst_valid", 32'(o_valid), 0);
    check("arst_busy", 32'(o_busy), 0);
    repeat (2) tick();
    i_rst = 0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    check("post_rst_busy", 32'(o_busy), 0);
    check("post_rst_valid", 32'(o_valid), 0);
    check("post_rst_abort", 32'(ab_cycles - ab0), 0);
    send_frame(4'd8, 8'h5A, 1'b0);
    check("post_rst_data", 32'(o_data), 32'h5A);
    for (int i = 0; i < 50 && o_busy; i++) tick();
    check("final_idle", 32'(o_busy), 0);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- SPI shift-in endpoint. It is the far end of spi_core's serial link and reconstructs the words spi_core transmits.
- i_sck and i_mosi are oversampled in the i_clk domain. Bits are captured MSB-first on each i_sck falling edge.
- Each frame is armed by a start pulse. Every completed word is presented on a one-deep valid/ready output register.
- Overrun and abort are flagged for the consuming logic.

Parameters:
- DATA_WIDTH, 8: maximum word width in bits; width of o_data.
- SYNC_STAGES, 2: synchronizer flops on i_sck and i_mosi; legal range 2..3.

Ports:
- i_clk  in  1  system clock; i_sck and i_mosi are asynchronous to it.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  i_clk-synchronous frame-start pulse; arms reception.
- i_data_length  in  4  bits per frame, sampled when i_start is high.
- i_sck  in  1  serial clock, idle low.
- i_mosi  in  1  serial data, stable around i_sck falling edges.
- i_ready  in  1  consumer accepts o_data when i_ready and o_valid are both high on a rising edge.
- o_data  out  DATA_WIDTH  received word, right-aligned, upper bits zero.
- o_valid  out  1  o_data holds an unconsumed word.
- o_busy  out  1  frame in progress.
- o_overrun  out  1  one-cycle pulse: an unconsumed word was overwritten.
- o_abort  out  1  one-cycle pulse: a partial frame was discarded by i_start.

Behaviour:
- Reset (async, i_rst=1): all outputs 0. Synchronizers cleared to 0. Shift register 0, bit counter 0, state IDLE.
- Synchronization and edge detection:
  - i_sck and i_mosi each pass through SYNC_STAGES flops.
  - A further flop holds the previous synchronized sck.
  - fall = prev_sck & ~sync_sck.
- Capture latency: a fall event is acted on SYNC_STAGES+1 i_clk rising edges after the i_sck falling edge.
- The bit captured is sync_mosi in that same cycle.
- i_sck high and low phases must each last ≥ SYNC_STAGES+1 i_clk periods. Behaviour is undefined below that.
- Length rule: len = i_data_length. If i_data_length is 0 or greater than DATA_WIDTH, len = DATA_WIDTH (clamp).
- States:
  - IDLE: o_busy=0. Fall events are ignored. i_start → RECV, with shift register cleared, counter cleared and len latched.
  - RECV: o_busy=1.
    - On each fall: shift = {shift[DATA_WIDTH-2:0], bit}, counter+1.
    - On the fall that makes counter == len: o_data <= {shift, bit} masked to len bits, o_valid <= 1, state → IDLE.
    - o_busy drops on that same edge.
  - i_start in RECV with counter > 0: o_abort pulses for 1 cycle. The partial word is discarded and reception re-arms.
  - i_start in RECV with counter == 0: re-arms silently.
  - i_start and fall on the same edge: i_start wins and the fall is discarded.
- Output handshake:
  - o_valid stays high until the first edge where i_ready=1, which clears it. o_data holds its value after being consumed.
  - Word completes while o_valid=1 and i_ready=0: o_data is overwritten, o_valid stays 1, o_overrun pulses 1 cycle.
  - Word completes on the same edge as an accept (o_valid=1, i_ready=1): the new word is loaded, o_valid stays 1, no overrun.
  - i_ready with o_valid=0 has no effect.
- Reset mid-frame: everything returns to reset values immediately. No o_abort pulse.
- Received bits arrive MSB-first. A len-bit frame therefore lands in o_data[len-1:0].

Test Plan:
- Length 8, spi_core sends 0x32 → after the 8th fall: o_data=0x32, o_valid=1, o_busy=0; i_ready pulse clears o_valid.
- Length 4, bits 1,0,1,1 → o_data=0x0B; upper bits 0.
- Length 0 and length 12 (DATA_WIDTH=8), byte 0xA5 → both complete after exactly 8 bits with o_data=0xA5.
- Two frames 0x11 then 0x22, i_ready held 0 → o_data=0x22, o_valid=1, o_overrun high for exactly 1 cycle.
- Same two frames, with i_ready=1 on the completion edge of 0x22 → o_data=0x22, o_valid=1, no overrun.
- i_start after 3 bits of 0xFF, then full frame 0x3C → o_abort pulses once, o_data=0x3C.
- i_rst asserted after 5 bits → outputs 0 asynchronously; post-reset sck edges are ignored until i_start.
